sm_controller: RTL
==================

# sm_controller

Instruction register, decoder and control state machine for the Simple RISC Machine. It sits directly upstream of the datapath. It latches a 16-bit instruction, decodes register fields and immediates, and sequences the datapath control signals over several cycles to execute MOV, ADD, CMP, AND and MVN. It uses a start/wait handshake with the surrounding test harness or top level.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in  in  16  instruction word
- load  in  1  instruction-register load enable
- s  in  1  start execution of the latched instruction
- w  out  1  controller idle/waiting (1 = ready for new s)
- readnum  out  3  register-file read address
- writenum  out  3  register-file write address
- write  out  1  register-file write enable
- vsel  out  4  one-hot writeback select: 0001 mdata, 0010 sximm8, 0100 PC, 1000 datapath_out
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel, bsel  out  1 each  A operand (1 = zero), B operand (1 = sximm5)
- shift  out  2  shifter op
- ALUop  out  2  ALU op: 00 add, 01 sub, 10 and, 11 not B
- sximm5, sximm8  out  16 each  sign-extended IR[4:0] and IR[7:0]

## Operation
- IR: 16-bit, captures `in` on rising clk when load=1 **and** state=WAIT; load is ignored in other states. All decode uses IR, never `in`.
- Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Instructions:
  - 110/10 MOV Rn,#im8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - All other opcode/op combinations are undefined.
- Moore FSM, outputs combinational from state+IR. States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, COMPUTE, WRITE_REG.
- WAIT:
  - w=1.
  - s=1 → DECODE, otherwise stay.
- DECODE:
  - MOV imm → WRITE_IMM.
  - MOV reg or MVN → GET_B.
  - ADD, CMP, AND → GET_A.
  - Undefined → WAIT, with no enables asserted.
- WRITE_IMM: writenum=Rn, vsel=0010, write=1 → WAIT.
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → COMPUTE.
- COMPUTE: bsel=0.
  - asel=1 for MOV reg, 0 otherwise.
  - ALUop=00 for MOV reg, op otherwise.
  - CMP: loads=1, loadc=0 → WAIT.
  - Other ops: loadc=1, loads=0 → WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=1000, write=1 → WAIT.
- shift = sh in all states except when IR is MOV imm, where it is 00.
- sximm5/sximm8 are always driven from the current IR.
- Defaults in any state not listed above:
  - write, loada, loadb, loadc, loads, asel, bsel = 0
  - readnum = writenum = 000
  - vsel = 1000

## Timing
- Reset (async, immediate on reset_n low): state=WAIT, IR=16'h0000, w=1, all enables 0, vsel=1000, readnum/writenum=0, sximm5/sximm8=0.
- Reset mid-instruction aborts at once. No write or load is asserted after reset_n falls, and an in-flight writeback is lost.
- Latency is counted from the edge sampling s=1 in WAIT to w=1:
  - MOV imm: 2 cycles
  - MOV reg, MVN, CMP: 4 cycles
  - ADD, AND: 5 cycles
  - Undefined: 1 cycle
- load and s high on the same WAIT edge: IR takes the new word and DECODE uses it.
- s held high on return to WAIT starts the next instruction on the following edge, with no extra idle cycle required.
- s outside WAIT is ignored.

## Test plan
- Reset, then load `D007` and pulse s:
  - Required: WRITE_IMM with writenum=0, vsel=0010, sximm8=0007, write=1.
  - w=0 for 2 cycles, then 1.
- Load `D5FD` and pulse s:
  - Required: sximm8=FFFD, writenum=5.
  - Repeat with load=1 asserted during DECODE: IR must stay D5FD.
- Load `A148` (ADD R2,R1,R0,LSL#1) and pulse s:
  - Required sequence: GET_A (readnum=1, loada), GET_B (readnum=0, loadb), COMPUTE (shift=01, ALUop=00, loadc), WRITE_REG (writenum=2, vsel=1000, write).
  - w returns after 5 cycles.
- Load `A900` (CMP R1,R0) and pulse s:
  - Required in COMPUTE: ALUop=01, loads=1, loadc=0.
  - write is never asserted; back in WAIT after 4 cycles.
- Run `C080` (MOV R4,R0) and `B860` (MVN R3,R0):
  - MOV reg: asel=1, ALUop=00.
  - MVN: ALUop=11, no loada.
  - Write targets 4 and 3 respectively.
- Run undefined `E000`:
  - Required: back in WAIT after 1 cycle, no enables asserted.
- Drop reset_n in GET_B of an ADD:
  - Required: w=1 and loadb=0 combinationally; next s runs cleanly with IR=0000.

Source files
------------

// File: rtl/sm_controller_if.sv
// Instruction/handshake and datapath-control bundle between the SRM controller and its surroundings.
interface sm_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );
endinterface

// File: rtl/sm_controller.sv
// Simple RISC Machine controller: instruction register, field decode and the Moore
// sequencer that steps the datapath through MOV/ADD/CMP/AND/MVN.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// WAIT         | idle, w=1; IR may load; s starts the latched instruction
// DECODE       | classify IR; undefined encodings fall straight back to WAIT
// WRITE_IMM    | write sximm8 into Rn
// GET_A        | read Rn into A
// GET_B        | read Rm into B
// COMPUTE      | run shifter/ALU; CMP loads status, others load C
// WRITE_REG    | write datapath_out into Rd
module sm_controller (
    input  logic           clk,
    input  logic           reset_n,
    sm_controller_if.slave bus
);
    localparam logic [2:0] ST_WAIT      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_WRITE_IMM = 3'd2;
    localparam logic [2:0] ST_GET_A     = 3'd3;
    localparam logic [2:0] ST_GET_B     = 3'd4;
    localparam logic [2:0] ST_COMPUTE   = 3'd5;
    localparam logic [2:0] ST_WRITE_REG = 3'd6;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // Loading only in WAIT keeps IR stable for the whole instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= 16'h0000;
        end else if ((state == ST_WAIT) && bus.load) begin
            ir <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_WAIT;
        case (state)
            ST_WAIT:      state_next = bus.s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm)                 state_next = ST_WRITE_IMM;
                else if (is_mov_reg || is_mvn)  state_next = ST_GET_B;
                else if (is_alu)                state_next = ST_GET_A;
                else                            state_next = ST_WAIT;
            end
            ST_WRITE_IMM: state_next = ST_WAIT;
            ST_GET_A:     state_next = ST_GET_B;
            ST_GET_B:     state_next = ST_COMPUTE;
            ST_COMPUTE:   state_next = is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_next = ST_WAIT;
            default:      state_next = ST_WAIT;
        endcase
    end

    always_comb begin
        bus.w        = 1'b0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.readnum  = 3'b000;
        bus.writenum = 3'b000;
        bus.vsel     = 4'b1000;
        bus.ALUop    = 2'b00;
        case (state)
            ST_WAIT: bus.w = 1'b1;
            ST_WRITE_IMM: begin
                bus.writenum = rn;
                bus.vsel     = 4'b0010;
                bus.write    = 1'b1;
            end
            ST_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            ST_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            ST_COMPUTE: begin
                // MOV reg is computed as 0 + shifted Rm, hence the zeroed A operand.
                bus.asel  = is_mov_reg;
                bus.ALUop = is_mov_reg ? 2'b00 : op;
                bus.loads = is_cmp;
                bus.loadc = !is_cmp;
            end
            ST_WRITE_REG: begin
                bus.writenum = rd;
                bus.vsel     = 4'b1000;
                bus.write    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.shift  = is_mov_imm ? 2'b00 : sh;
    assign bus.sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};
endmodule
